dmem_responder: RTL and testbench

// Byte-addressable data memory responder: target end of the CPU's MEM-stage load/store

---
 rtl/dmem_if.sv | 22 ++
 rtl/dmem_responder.sv | 119 +++++++++++
 tb/tb_dmem_responder.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: load/store request/response bundle between the MEM stage and the data memory
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: byte-addressable RV32I data memory with wait states and error responses
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input logic   clk,
    input logic   r,
    dmem_if.slave bus
);
    localparam int DEPTH = 2 ** (ADDR_W - 2);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem [DEPTH];
    logic        accept;
    logic        go;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [2:0]  c_f3;
    logic        legal;
    logic        c_err;
    logic [1:0]  lane;
    logic [31:0] word;
    logic [7:0]  byt;
    logic [15:0] half;
    logic [31:0] c_rdata;
    logic [3:0]  be;
    logic [31:0] wrep;
    assign accept        = bus.req_valid && state == IDLE;
    assign bus.req_ready = state == IDLE;
    assign bus.busy      = state != IDLE;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;
    // Commit-time view of the access: live inputs for a zero-wait accept, captured fields otherwise
    always_comb begin
        c_we    = state == IDLE ? bus.req_we : we_q;
        c_addr  = state == IDLE ? bus.req_addr : addr_q;
        c_wdata = state == IDLE ? bus.req_wdata : wdata_q;
        c_f3    = state == IDLE ? bus.req_funct3 : f3_q;
        go      = !r && ((accept && LATENCY == 0) || (state == WAIT && cnt == 4'd0));
        legal   = c_f3 == 3'b000 || c_f3 == 3'b001 || c_f3 == 3'b010 ||
                  (!c_we && (c_f3 == 3'b100 || c_f3 == 3'b101));
        c_err   = !legal || (c_f3[1:0] == 2'b01 && c_addr[0]) ||
                  (c_f3[1:0] == 2'b10 && c_addr[1:0] != 2'b00) || (|c_addr[31:ADDR_W]);
        lane    = c_addr[1:0];
        word    = mem[c_addr[ADDR_W-1:2]];
        byt     = word[{lane, 3'b000} +: 8];
        half    = lane[1] ? word[31:16] : word[15:0];
        c_rdata = (c_we || c_err) ? 32'd0 :
                  c_f3 == 3'b000 ? {{24{byt[7]}}, byt} :
                  c_f3 == 3'b001 ? {{16{half[15]}}, half} :
                  c_f3 == 3'b100 ? {24'd0, byt} :
                  c_f3 == 3'b101 ? {16'd0, half} : word;
        be      = c_f3[1:0] == 2'b00 ? 4'b0001 << lane :
                  c_f3[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wrep    = c_f3[1:0] == 2'b00 ? {4{c_wdata[7:0]}} :
                  c_f3[1:0] == 2'b01 ? {2{c_wdata[15:0]}} : c_wdata;
    end
    // Store commit on the edge entering RESP; contents survive reset
    always_ff @(posedge clk) begin
        if (go && c_we && !c_err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[c_addr[ADDR_W-1:2]][i*8 +: 8] <= wrep[i*8 +: 8];
    end
    // Request/wait/response sequencing with registered response
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            f3_q      <= 3'b000;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    we_q    <= bus.req_we;
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    f3_q    <= bus.req_funct3;
                    if (LATENCY == 0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= c_rdata;
                        rsp_err   <= c_err;
                    end else begin
                        cnt   <= 4'(LATENCY - 1);
                        state <= WAIT;
                    end
                end
                WAIT: if (cnt == 4'd0) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= c_rdata;
                    rsp_err   <= c_err;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                RESP: if (bus.rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: four responders (LATENCY 0..3) checked against a byte-array memory model
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        r = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_funct3 = 3'b000;
    logic        rsp_ready = 1'b1;
    int          sel = 0;
    logic [3:0]  rq, rv, re, by;
    logic [31:0] rd [4];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit [7:0]    ref_mem [4][1024];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gi
        dmem_if b ();
        assign b.req_valid  = req_valid && sel == g;
        assign b.req_we     = req_we;
        assign b.req_addr   = req_addr;
        assign b.req_wdata  = req_wdata;
        assign b.req_funct3 = req_funct3;
        assign b.rsp_ready  = rsp_ready && sel == g;
        assign rq[g] = b.req_ready;
        assign rv[g] = b.rsp_valid;
        assign re[g] = b.rsp_err;
        assign by[g] = b.busy;
        assign rd[g] = b.rsp_rdata;
        dmem_responder #(.ADDR_W(10), .LATENCY(g)) dut (.clk(clk), .r(r), .bus(b));
    end

    function automatic void model(input int k, input bit we, input logic [31:0] a, wd,
                                  input logic [2:0] f3, output logic [31:0] erd, output bit eerr);
        int n;
        logic [31:0] v;
        n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : f3[1:0] == 2'd2 ? 4 : 0;
        erd = 32'd0;
        if (f3 == 3 || f3 >= 6 || (we && f3 >= 4)) eerr = 1;
        else eerr = (a % n != 0) || (a >= 1024);
        if (eerr) return;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[k][a + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[k][a + i];
            if (!f3[2] && n < 4 && v[8*n - 1]) v = v | ~((32'h1 << (8*n)) - 1);
            erd = v;
        end
    endfunction

    task automatic do_txn(input int k, input bit we, input logic [31:0] a, wd, input logic [2:0] f3,
                          output logic [31:0] rdo, output logic eo, output int lat);
        int n;
        @(negedge clk);
        sel = k; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
        req_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        while (!rq[k] && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
        lat = -1;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rv[k]) begin lat = n; break; end
        end
        rdo = rd[k]; eo = re[k];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        r = 1'b1;
        #12;
        n_cmp++;
        if ({rq, rv, re, by} !== 16'hF000) begin
            n_bad++; $display("FAIL reset_flags got %h exp F000", {rq, rv, re, by});
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (rd[k] !== 32'd0) begin n_bad++; $display("FAIL reset_rdata%0d got %h exp 0", k, rd[k]); end
        end
        @(negedge clk); r = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({rq, by} !== 8'hF0) begin n_bad++; $display("FAIL post_reset got %h exp F0", {rq, by}); end
    endtask

    task automatic test_lanes_lat0();
        logic [31:0] d; logic e; int l;
        do_txn(0, 1, 32'h20, 32'hDEADBEEF, 3'b010, d, e, l);
        n_cmp++;
        if ({l, e, d} !== {32'd0, 1'b0, 32'd0}) begin
            n_bad++; $display("FAIL sw_lat0 got lat=%0d err=%b d=%h exp lat=0 err=0 d=0", l, e, d);
        end
        do_txn(0, 0, 32'h20, 0, 3'b010, d, e, l);
        n_cmp++;
        if ({e, d} !== {1'b0, 32'hDEADBEEF}) begin n_bad++; $display("FAIL lw_20 got %b/%h exp 0/DEADBEEF", e, d); end
        do_txn(0, 1, 32'h21, 32'h12345680, 3'b000, d, e, l);
        do_txn(0, 0, 32'h20, 0, 3'b010, d, e, l);
        n_cmp++;
        if ({e, d} !== {1'b0, 32'hDEAD80EF}) begin n_bad++; $display("FAIL sb_merge got %b/%h exp 0/DEAD80EF", e, d); end
        do_txn(0, 0, 32'h21, 0, 3'b000, d, e, l);
        n_cmp++;
        if ({e, d} !== {1'b0, 32'hFFFFFF80}) begin n_bad++; $display("FAIL lb_21 got %b/%h exp 0/FFFFFF80", e, d); end
        do_txn(0, 0, 32'h21, 0, 3'b100, d, e, l);
        n_cmp++;
        if ({e, d} !== {1'b0, 32'h00000080}) begin n_bad++; $display("FAIL lbu_21 got %b/%h exp 0/00000080", e, d); end
        do_txn(0, 0, 32'h22, 0, 3'b001, d, e, l);
        n_cmp++;
        if ({e, d} !== {1'b0, 32'hFFFFDEAD}) begin n_bad++; $display("FAIL lh_22 got %b/%h exp 0/FFFFDEAD", e, d); end
        do_txn(0, 0, 32'h22, 0, 3'b101, d, e, l);
        n_cmp++;
        if ({e, d} !== {1'b0, 32'h0000DEAD}) begin n_bad++; $display("FAIL lhu_22 got %b/%h exp 0/0000DEAD", e, d); end
        do_txn(0, 1, 32'h24, 32'hAAAA7654, 3'b001, d, e, l);
        do_txn(0, 1, 32'h26, 32'hBBBB3210, 3'b001, d, e, l);
        do_txn(0, 0, 32'h24, 0, 3'b010, d, e, l);
        n_cmp++;
        if ({e, d} !== {1'b0, 32'h32107654}) begin n_bad++; $display("FAIL sh_pair got %b/%h exp 0/32107654", e, d); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e; int l;
        logic [31:0] ea [6];
        logic [2:0]  ef [6];
        bit          ew [6];
        ea = '{32'h23, 32'h22, 32'h400, 32'h20, 32'h20, 32'h21};
        ef = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b011, 3'b001};
        ew = '{0, 0, 1, 0, 1, 1};
        do_txn(0, 1, 32'h0, 32'h01020304, 3'b010, d, e, l);
        for (int i = 0; i < 6; i++) begin
            do_txn(0, ew[i], ea[i], 32'h55555555, ef[i], d, e, l);
            n_cmp++;
            if ({e, d} !== {1'b1, 32'd0}) begin n_bad++; $display("FAIL err_case%0d got %b/%h exp 1/0", i, e, d); end
        end
        do_txn(0, 0, 32'h20, 0, 3'b010, d, e, l);
        n_cmp++;
        if ({e, d} !== {1'b0, 32'hDEAD80EF}) begin n_bad++; $display("FAIL err_nowrite20 got %b/%h exp 0/DEAD80EF", e, d); end
        do_txn(0, 0, 32'h0, 0, 3'b010, d, e, l);
        n_cmp++;
        if ({e, d} !== {1'b0, 32'h01020304}) begin n_bad++; $display("FAIL err_noalias0 got %b/%h exp 0/01020304", e, d); end
    endtask

    task automatic test_reset_midwait();
        logic [31:0] d; logic e; int l; bit seen;
        do_txn(3, 1, 32'h10, 32'h55667788, 3'b010, d, e, l);
        @(negedge clk);
        sel = 3; req_we = 1; req_addr = 32'h10; req_wdata = 32'h11223344; req_funct3 = 3'b010; req_valid = 1;
        @(posedge clk); #1; req_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (by[3] !== 1'b1) begin n_bad++; $display("FAIL midwait_busy got %b exp 1", by[3]); end
        r = 1'b1; #1;
        n_cmp++;
        if ({rq[3], rv[3], by[3]} !== 3'b100) begin
            n_bad++; $display("FAIL midwait_reset got rdy/vld/busy=%b exp 100", {rq[3], rv[3], by[3]});
        end
        @(negedge clk); r = 1'b0;
        seen = 0;
        repeat (6) begin @(negedge clk); if (rv[3] || !rq[3]) seen = 1; end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL midwait_dropped got stray response/busy exp idle"); end
        do_txn(3, 0, 32'h10, 0, 3'b010, d, e, l);
        n_cmp++;
        if ({e, d} !== {1'b0, 32'h55667788}) begin n_bad++; $display("FAIL midwait_old got %b/%h exp 0/55667788", e, d); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d, v0; logic e; int l; bit bad;
        do_txn(2, 1, 32'h40, 32'hCAFEF00D, 3'b010, d, e, l);
        @(negedge clk);
        sel = 2; req_we = 0; req_addr = 32'h40; req_funct3 = 3'b010; req_valid = 1; rsp_ready = 0;
        @(posedge clk); #1;
        req_we = 1; req_addr = 32'h44; req_wdata = 32'h12345678;
        l = -1;
        for (int n = 0; n < 20; n++) begin @(negedge clk); if (rv[2]) begin l = n; break; end end
        v0 = rd[2];
        n_cmp++;
        if ({l, v0} !== {32'd2, 32'hCAFEF00D}) begin
            n_bad++; $display("FAIL bp_first got lat=%0d d=%h exp lat=2 d=CAFEF00D", l, v0);
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rv[2] !== 1'b1 || rd[2] !== v0 || rq[2] !== 1'b0) bad = 1;
        end
        n_cmp++;
        if (bad) begin n_bad++; $display("FAIL bp_hold got vld=%b d=%h rdy=%b exp 1/%h/0", rv[2], rd[2], rq[2], v0); end
        rsp_ready = 1;
        @(negedge clk);
        n_cmp++;
        if ({rq[2], rv[2]} !== 2'b10) begin n_bad++; $display("FAIL bp_release got rdy/vld=%b exp 10", {rq[2], rv[2]}); end
        @(posedge clk); #1; req_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (by[2] !== 1'b1) begin n_bad++; $display("FAIL bp_reaccept got busy=%b exp 1", by[2]); end
        for (int n = 0; n < 20 && !rv[2]; n++) @(negedge clk);
        @(posedge clk); #1;
        do_txn(2, 0, 32'h44, 0, 3'b010, d, e, l);
        n_cmp++;
        if ({e, d} !== {1'b0, 32'h12345678}) begin n_bad++; $display("FAIL bp_store got %b/%h exp 0/12345678", e, d); end
    endtask

    task automatic test_random();
        logic [31:0] d, a, wd, xd; logic e; int l; bit xe, we; logic [2:0] f3;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 16; w++) begin
                wd = $urandom;
                model(k, 1, 32'h100 + 4*w, wd, 3'b010, xd, xe);
                do_txn(k, 1, 32'h100 + 4*w, wd, 3'b010, d, e, l);
            end
            for (int t = 0; t < 30; t++) begin
                we = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
                a = $urandom_range(0, 7) == 0 ? ($urandom | 32'h400) : 32'h100 + $urandom_range(0, 63);
                wd = $urandom;
                model(k, we, a, wd, f3, xd, xe);
                do_txn(k, we, a, wd, f3, d, e, l);
                n_cmp++;
                if ({e, d} !== {xe, xd} || l != k) begin
                    n_bad++;
                    $display("FAIL rand L%0d we=%b f3=%0d a=%h got %b/%h lat=%0d exp %b/%h lat=%0d",
                             k, we, f3, a, e, d, l, xe, xd, k);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [$];
        logic [31:0] got_q [$];
        int acc_q [$];
        logic [31:0] xd; bit xe, acc; int idx;
        for (int i = 0; i < 6; i++) begin model(1, 0, 32'h100 + 8*i, 0, 3'b010, xd, xe); exp_q.push_back(xd); end
        @(negedge clk);
        sel = 1; rsp_ready = 1; idx = 0;
        req_we = 0; req_funct3 = 3'b010; req_addr = 32'h100; req_valid = 1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (rv[1]) got_q.push_back(rd[1]);
            acc = rq[1] && req_valid;
            if (acc) acc_q.push_back(cyc);
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx == 6) req_valid = 0; else req_addr = 32'h100 + 8*idx;
            end
        end
        n_cmp++;
        if (acc_q.size() != 6 || got_q.size() != 6) begin
            n_bad++; $display("FAIL b2b_count got acc=%0d rsp=%0d exp 6/6", acc_q.size(), got_q.size());
        end
        for (int i = 1; i < acc_q.size(); i++) begin
            n_cmp++;
            if (acc_q[i] - acc_q[i-1] != 3) begin
                n_bad++; $display("FAIL b2b_spacing%0d got %0d exp 3", i, acc_q[i] - acc_q[i-1]);
            end
        end
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_data%0d got %h exp %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lanes_lat0();
        test_errors();
        test_reset_midwait();
        test_backpressure();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
